// File: rtl/pixel_pkg.sv
// Shared widths and the byte-select helper for the 64-bit to 8-bit pixel unpacker.
package pixel_pkg;

  localparam int PIXEL_W      = 8;
  localparam int WORD_W       = 64;
  localparam int PIX_PER_WORD = 8;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);

  // Pixel k of a packed word sits in bits [8k+7:8k]; k=0 is emitted first.
  function automatic logic [PIXEL_W-1:0] word_pixel(input logic [WORD_W-1:0] word,
                                                    input logic [IDX_W-1:0]  idx);
    return word[idx*PIXEL_W +: PIXEL_W];
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous FIFO of packed words with a registered write-ready that
// already accounts for the write/read happening on the current edge.
module word_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [WORD_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_wr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_wr_ready;
  logic              w_wr;
  logic              w_rd;
  logic [CW-1:0]     w_count_nxt;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_rd_data   = r_mem[r_rd_ptr];
  assign o_wr_ready  = r_wr_ready;
  assign w_wr        = i_wr_en & ~o_full;
  assign w_rd        = i_rd_en & ~o_empty;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);

  // Ready is computed from the post-edge occupancy so it never admits a write into a full buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      r_wr_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/pixel_unpacker.sv
// Unpacks buffered 64-bit words into an 8-bit pixel stream with frame
// position flags (start of frame, end of line, end of frame).
module pixel_unpacker
  import pixel_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof,
  output logic               frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [WORD_W-1:0] w_fifo_data;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic              w_consume;
  logic              w_last_idx;
  logic              w_at_eol;
  logic              w_at_last_line;

  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic              r_loaded;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_frame_done;

  word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_wr_en    (w_fifo_wr),
    .i_wr_data  (in_data),
    .i_rd_en    (w_fifo_rd),
    .o_rd_data  (w_fifo_data),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_wr_ready (in_ready)
  );

  assign w_fifo_wr      = in_valid & in_ready & ~w_fifo_full;
  assign w_consume      = r_loaded & out_ready;
  assign w_last_idx     = (r_idx == IDX_W'(PIX_PER_WORD - 1));
  // Refill when the stage is empty or its last pixel leaves this edge, so words chain without a bubble.
  assign w_fifo_rd      = (~r_loaded | (w_consume & w_last_idx)) & ~w_fifo_empty;
  assign w_at_eol       = (r_x == XW'(IMG_WIDTH - 1));
  assign w_at_last_line = (r_y == YW'(IMG_HEIGHT - 1));

  assign out_pixel  = word_pixel(r_word, r_idx);
  assign out_valid  = r_loaded;
  assign out_sof    = r_loaded & (r_x == '0) & (r_y == '0);
  assign out_eol    = r_loaded & w_at_eol;
  assign out_eof    = r_loaded & w_at_eol & w_at_last_line;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word   <= '0;
      r_idx    <= '0;
      r_loaded <= 1'b0;
    end else if (w_fifo_rd) begin
      r_word   <= w_fifo_data;
      r_idx    <= '0;
      r_loaded <= 1'b1;
    end else if (w_consume) begin
      if (w_last_idx) begin
        r_idx    <= '0;
        r_loaded <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_consume & w_at_eol & w_at_last_line;
      if (w_consume) begin
        if (w_at_eol) begin
          r_x <= '0;
          r_y <= w_at_last_line ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Directed bench for pixel_unpacker: table-driven frame vectors plus hand-built
// corner sequences, with a negedge scoreboard for pixel order and flags.
module tb_pixel_unpacker;

  localparam int W = 16;
  localparam int H = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof, out_eol, out_eof, frame_done;

  pixel_unpacker #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]     word;
    logic [0:7][7:0] seq;
    logic            sof_first;
    logic            eol_last;
    logic            eof_last;
  } vec_t;

  typedef struct {
    logic [7:0] pix;
    logic       sof, eol, eof;
    int         cyc;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  obs_t       got_q[$];
  int         mx = 0, my = 0, cyc = 0, fd_count = 0;
  logic       prev_stall = 1'b0, exp_fd = 1'b0;
  logic [10:0] prev_vec, cur_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: outputs sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      mx = 0; my = 0;
      prev_stall = 1'b0;
      exp_fd = 1'b0;
    end else begin
      cur_vec = {out_valid, out_pixel, out_sof, out_eol, out_eof};
      if (prev_stall) chk("stall_hold", 64'(cur_vec), 64'(prev_vec));
      prev_stall = out_valid && !out_ready;
      prev_vec   = cur_vec;
      if (exp_fd || frame_done) chk("frame_done", 64'(frame_done), 64'(exp_fd));
      if (frame_done) fd_count++;
      exp_fd = 1'b0;
      if (!out_valid) chk("flags_idle", 64'({out_sof, out_eol, out_eof}), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 64'(out_pixel), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", 64'(out_pixel), 64'(e));
        end
        chk("sof", 64'(out_sof), 64'(mx == 0 && my == 0));
        chk("eol", 64'(out_eol), 64'(mx == W-1));
        chk("eof", 64'(out_eof), 64'(mx == W-1 && my == H-1));
        got_q.push_back('{pix: out_pixel, sof: out_sof, eol: out_eol, eof: out_eof, cyc: cyc});
        exp_fd = (mx == W-1 && my == H-1);
        if (mx == W-1) begin
          mx = 0;
          my = (my == H-1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      if (in_valid && in_ready)
        for (int k = 0; k < 8; k++) exp_q.push_back(in_data[8*k +: 8]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_got(input int n);
    int c = 0;
    while (got_q.size() < n && c < 200) begin step(); c++; end
    if (got_q.size() < n) chk("wait_got_timeout", 64'(got_q.size()), 64'(n));
  endtask

  task automatic drain();
    int c = 0;
    while ((out_valid || exp_q.size() != 0) && c < 300) begin step(); c++; end
    if (out_valid || exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("Watchdog expired before completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[4];
    int   gbase, acc, sent;

    tbl[0] = '{word: 64'h8877665544332211,
               seq: {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88},
               sof_first: 1'b1, eol_last: 1'b0, eof_last: 1'b0};
    tbl[1] = '{word: 64'h0123456789ABCDEF,
               seq: {8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01},
               sof_first: 1'b0, eol_last: 1'b1, eof_last: 1'b0};
    tbl[2] = '{word: 64'hF0E1D2C3B4A59687,
               seq: {8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0},
               sof_first: 1'b0, eol_last: 1'b0, eof_last: 1'b0};
    tbl[3] = '{word: 64'h00FF00FF7F80017E,
               seq: {8'h7E, 8'h01, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'hFF, 8'h00},
               sof_first: 1'b0, eol_last: 1'b1, eof_last: 1'b1};

    // Reset state and in_ready release
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_out_pixel", 64'(out_pixel), 64'd0);
    reset_n = 1'b1;
    chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    step();
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Single word: two-cycle latency then 0x00..0x07 back to back
    in_valid = 1'b1; in_data = 64'h0706050403020100;
    step();
    in_valid = 1'b0;
    chk("latency_early", 64'(out_valid), 64'd0);
    step();
    chk("first_sof", 64'(out_sof), 64'd1);
    for (int k = 0; k < 8; k++) begin
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_pixel", 64'(out_pixel), 64'(k));
      step();
    end
    chk("single_empty", 64'(out_valid), 64'd0);

    // Full frame from the vector table, written back to back
    do_reset();
    got_q.delete();
    fd_count = 0;
    for (int i = 0; i < 4; i++) begin
      chk("frame_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_data = tbl[i].word;
      step();
    end
    in_valid = 1'b0;
    wait_got(32);
    if (got_q.size() >= 32) begin
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 8; k++) begin
          chk("tbl_pix", 64'(got_q[i*8+k].pix), 64'(tbl[i].seq[k]));
          chk("tbl_sof", 64'(got_q[i*8+k].sof), 64'(k == 0 && tbl[i].sof_first));
          chk("tbl_eol", 64'(got_q[i*8+k].eol), 64'(k == 7 && tbl[i].eol_last));
          chk("tbl_eof", 64'(got_q[i*8+k].eof), 64'(k == 7 && tbl[i].eof_last));
        end
      chk("frame_no_gap", 64'(got_q[31].cyc - got_q[0].cyc), 64'd31);
    end
    step(); step();
    chk("frame_done_count", 64'(fd_count), 64'd1);
    in_valid = 1'b1; in_data = 64'h5A4B3C2D1E0F6978;
    step();
    in_valid = 1'b0;
    wait_got(33);
    if (got_q.size() >= 33) begin
      chk("next_frame_sof", 64'(got_q[32].sof), 64'd1);
      chk("next_frame_pix", 64'(got_q[32].pix), 64'h78);
    end
    drain();

    // Backpressure: FIFO_DEPTH words plus one staged word, then nothing lost
    gbase = got_q.size();
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_data = 64'h1122334455667788 + 64'(i) * 64'h0101010101010101;
      if (in_ready) acc++;
      step();
    end
    chk("bp_accepted", 64'(acc), 64'(D + 1));
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("bp_pixels_out", 64'(got_q.size() - gbase), 64'(8 * (D + 1)));

    // Random out_ready stalls and sparse input
    gbase = got_q.size(); sent = 0;
    for (int i = 0; i < 120; i++) begin
      in_valid  = (sent < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    chk("rand_pixels_out", 64'(got_q.size() - gbase), 64'(8 * sent));

    // Reset mid-line (x=5) with two words still buffered
    do_reset();
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 20 && acc < 3; i++) begin
      in_valid = 1'b1; in_data = 64'hA0A1A2A3A4A5A6A7 ^ 64'(i);
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    step();
    chk("mid_setup_x", 64'(mx), 64'd5);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    gbase = got_q.size();
    in_valid = 1'b1; in_data = 64'hCAFEBABE13579BDF;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    wait_got(gbase + 1);
    if (got_q.size() > gbase) begin
      chk("post_rst_sof", 64'(got_q[gbase].sof), 64'd1);
      chk("post_rst_pix", 64'(got_q[gbase].pix), 64'hDF);
    end
    drain();
    chk("post_rst_count", 64'(got_q.size() - gbase), 64'd8);

    // Empty FIFO, new word arrives on the edge that consumes the last staged pixel
    do_reset();
    gbase = got_q.size();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h8071625344352617;
    step();
    in_valid = 1'b0;
    step(); step();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    out_ready = 1'b0;
    step();
    chk("last_staged_pix", 64'(out_pixel), 64'h80);
    chk("coinc_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = 64'h0F1E2D3C4B5A6978; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("coinc_bubble", 64'(out_valid), 64'd0);
    step();
    chk("coinc_valid", 64'(out_valid), 64'd1);
    chk("coinc_pix0", 64'(out_pixel), 64'h78);
    drain();
    chk("coinc_count", 64'(got_q.size() - gbase), 64'd16);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
